tempo_picker: RTL and testbench

- Sits directly downstream of the six-output comb filter bank in the beat-detection path.
- Rectifies each comb output and integrates it over a window of 2^WINDOW_LOG2 samples.
- At each window end, runs a sequential argmax over the six energies.
- Reports the winning tempo as an index and a BPM value, with a one-cycle valid pulse, to the display/control logic.

---
 rtl/tempo_picker.sv | 172 +++++++++++++++++
 tb/tb_tempo_picker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tempo_picker.sv
// tempo_picker: rectifies and integrates six comb-filter outputs over a
// window of 2^WINDOW_LOG2 samples, then scans the window energies for the
// strongest tempo and reports it with a one-cycle valid pulse.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   ready        sample strobe (same strobe that drives the comb bank)
//   comb60..240  signed 8-bit comb filter outputs
//   tempo_valid  one-cycle pulse when a new result is available
//   tempo_idx    winning index 0..5 (60, 90, 120, 180, 210, 240 BPM)
//   bpm          winning tempo in BPM
//   energy       winner's window energy
//   locked       winner energy above MIN_ENERGY
//   busy         argmax scan in progress
module tempo_picker #(
  parameter int unsigned COMB_LATENCY = 12,
  parameter int unsigned WINDOW_LOG2  = 10,
  parameter int unsigned MIN_ENERGY   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ready,
  input  logic signed [7:0]      comb60,
  input  logic signed [7:0]      comb90,
  input  logic signed [7:0]      comb120,
  input  logic signed [7:0]      comb180,
  input  logic signed [7:0]      comb210,
  input  logic signed [7:0]      comb240,
  output logic                   tempo_valid,
  output logic [2:0]             tempo_idx,
  output logic [7:0]             bpm,
  output logic [WINDOW_LOG2+7:0] energy,
  output logic                   locked,
  output logic                   busy
);

  localparam int unsigned ACC_W = 8 + WINDOW_LOG2;
  localparam int unsigned N     = 6;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state;
  logic [COMB_LATENCY-1:0] dly;
  logic [WINDOW_LOG2-1:0]  cnt;
  logic [ACC_W-1:0]        acc  [N];
  logic [ACC_W-1:0]        snap [1:N-1];
  logic [ACC_W-1:0]        best_val;
  logic [2:0]              best_idx;
  logic [2:0]              scan_idx;

  logic                    strobe_c;
  logic                    win_end_c;
  logic [7:0]              mag_c  [N];
  logic [ACC_W-1:0]        sum_c  [N];
  logic [ACC_W-1:0]        cand_c;
  logic                    upd_c;
  logic [ACC_W-1:0]        next_val_c;
  logic [2:0]              next_idx_c;

  // Magnitude of a two's-complement byte; -128 maps to 128 unsigned.
  function automatic logic [7:0] rectify(input logic [7:0] x);
    rectify = x[7] ? (~x + 8'd1) : x;
  endfunction

  function automatic logic [7:0] bpm_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    bpm_lut = 8'd60;
      3'd1:    bpm_lut = 8'd90;
      3'd2:    bpm_lut = 8'd120;
      3'd3:    bpm_lut = 8'd180;
      3'd4:    bpm_lut = 8'd210;
      3'd5:    bpm_lut = 8'd240;
      default: bpm_lut = 8'd0;
    endcase
  endfunction

  assign strobe_c  = dly[COMB_LATENCY-1];
  assign win_end_c = strobe_c && (cnt == '1);

  // Rectify, running sums and the scan comparator.
  always_comb begin
    mag_c[0] = rectify(8'(comb60));
    mag_c[1] = rectify(8'(comb90));
    mag_c[2] = rectify(8'(comb120));
    mag_c[3] = rectify(8'(comb180));
    mag_c[4] = rectify(8'(comb210));
    mag_c[5] = rectify(8'(comb240));
    for (int unsigned k = 0; k < N; k++) begin
      sum_c[k] = acc[k] + ACC_W'(mag_c[k]);
    end

    cand_c = '0;
    case (scan_idx)
      3'd1:    cand_c = snap[1];
      3'd2:    cand_c = snap[2];
      3'd3:    cand_c = snap[3];
      3'd4:    cand_c = snap[4];
      3'd5:    cand_c = snap[5];
      default: cand_c = '0;
    endcase

    // Strictly greater: ties keep the lower index.
    upd_c      = cand_c > best_val;
    next_val_c = upd_c ? cand_c : best_val;
    next_idx_c = upd_c ? scan_idx : best_idx;
  end

  // Delay line, integrators, snapshot and scan FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dly         <= '0;
      cnt         <= '0;
      for (int unsigned k = 0; k < N; k++) acc[k] <= '0;
      for (int unsigned k = 1; k < N; k++) snap[k] <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      scan_idx    <= '0;
      tempo_valid <= 1'b0;
      tempo_idx   <= '0;
      bpm         <= '0;
      energy      <= '0;
      locked      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dly[0] <= ready;
      for (int unsigned i = 1; i < COMB_LATENCY; i++) dly[i] <= dly[i-1];

      tempo_valid <= 1'b0;

      if (strobe_c) begin
        cnt <= cnt + WINDOW_LOG2'(1);
        for (int unsigned k = 0; k < N; k++) begin
          acc[k] <= win_end_c ? '0 : sum_c[k];
        end
      end

      // A window end always (re)starts the scan, dropping any scan in flight.
      if (win_end_c) begin
        for (int unsigned k = 1; k < N; k++) snap[k] <= sum_c[k];
        best_val <= sum_c[0];
        best_idx <= '0;
        scan_idx <= 3'd1;
        busy     <= 1'b1;
        state    <= SCAN;
      end else begin
        case (state)
          IDLE: ;
          SCAN: begin
            best_val <= next_val_c;
            best_idx <= next_idx_c;
            if (scan_idx == 3'd5) begin
              tempo_idx   <= next_idx_c;
              bpm         <= bpm_lut(next_idx_c);
              energy      <= next_val_c;
              locked      <= next_val_c > ACC_W'(MIN_ENERGY);
              tempo_valid <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              scan_idx <= scan_idx + 3'd1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tempo_picker.sv
// Self-checking bench for tempo_picker (WINDOW_LOG2=3, COMB_LATENCY=12).
// A window-level model predicts each result and when it appears; a compare
// process checks every output every cycle against it.
module tb_tempo_picker;

  localparam int LAT   = 12;
  localparam int WL    = 3;
  localparam int WIN   = 1 << WL;
  localparam int ACC_W = 8 + WL;
  localparam int MIN_E = 0;

  typedef int vec_t [6];
  typedef struct {
    int cyc;
    int idx;
    int en;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              ready;
  logic signed [7:0] comb60, comb90, comb120, comb180, comb210, comb240;
  logic              tempo_valid;
  logic [2:0]        tempo_idx;
  logic [7:0]        bpm;
  logic [ACC_W-1:0]  energy;
  logic              locked;
  logic              busy;

  tempo_picker #(.COMB_LATENCY(LAT), .WINDOW_LOG2(WL), .MIN_ENERGY(MIN_E)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .comb60(comb60), .comb90(comb90), .comb120(comb120),
    .comb180(comb180), .comb210(comb210), .comb240(comb240),
    .tempo_valid(tempo_valid), .tempo_idx(tempo_idx), .bpm(bpm),
    .energy(energy), .locked(locked), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state
  int   bpm_tab [6] = '{60, 90, 120, 180, 210, 240};
  int   win_cnt;
  int   win_sum [6];
  exp_t expq [$];
  int   busy_lo, busy_hi;
  int   h_idx, h_bpm, h_en, h_lock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    expq.delete();
    win_cnt = 0;
    foreach (win_sum[k]) win_sum[k] = 0;
    busy_lo = 1; busy_hi = 0;
    h_idx = 0; h_bpm = 0; h_en = 0; h_lock = 0;
  endtask

  // Called in the cycle the ready strobe is driven.
  task automatic model_sample(input vec_t v);
    int best;
    exp_t e;
    foreach (v[k]) win_sum[k] += (v[k] < 0) ? -v[k] : v[k];
    win_cnt++;
    if (win_cnt == WIN) begin
      best = 0;
      for (int k = 1; k < 6; k++) if (win_sum[k] > win_sum[best]) best = k;
      e.cyc = cyc + LAT + 6;
      e.idx = best;
      e.en  = win_sum[best];
      expq.push_back(e);
      busy_lo = cyc + LAT + 1;
      busy_hi = cyc + LAT + 5;
      win_cnt = 0;
      foreach (win_sum[k]) win_sum[k] = 0;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int ev;
      ev = 0;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        ev     = 1;
        h_idx  = expq[0].idx;
        h_bpm  = bpm_tab[expq[0].idx];
        h_en   = expq[0].en;
        h_lock = (expq[0].en > MIN_E) ? 1 : 0;
        void'(expq.pop_front());
      end
      chk("tempo_valid", int'(tempo_valid), ev);
      chk("tempo_idx", int'(tempo_idx), h_idx);
      chk("bpm", int'(bpm), h_bpm);
      chk("energy", int'(energy), h_en);
      chk("locked", int'(locked), h_lock);
      chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  task automatic drive_comb(input vec_t v);
    comb60  = 8'(v[0]);
    comb90  = 8'(v[1]);
    comb120 = 8'(v[2]);
    comb180 = 8'(v[3]);
    comb210 = 8'(v[4]);
    comb240 = 8'(v[5]);
  endtask

  // Entered and left just after a rising edge; gap = cycles until the next strobe.
  task automatic send_sample(input vec_t v, input int gap);
    drive_comb(v);
    ready = 1'b1;
    model_sample(v);
    @(posedge clk); #1;
    ready = 1'b0;
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic send_window(input vec_t v);
    for (int i = 0; i < WIN; i++) send_sample(v, 13);
  endtask

  task automatic rand_vec(output vec_t v);
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 3) == 0) v[k] = int'($urandom_range(0, 4)) - 2;
      else                           v[k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    ready = 1'b0;
    model_clear();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Hand-computed expectations for directed windows.
  task automatic wait_valid(input int ei, input int eb, input int ee, input int el);
    bit seen;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (tempo_valid) seen = 1;
    end
    if (seen) begin
      chk("lit_idx", int'(tempo_idx), ei);
      chk("lit_bpm", int'(bpm), eb);
      chk("lit_energy", int'(energy), ee);
      chk("lit_locked", int'(locked), el);
    end else begin
      chk("lit_valid_timeout", 0, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, int'(tempo_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_idx"}, int'(tempo_idx), 0);
    chk({tag, "_bpm"}, int'(bpm), 0);
    chk({tag, "_energy"}, int'(energy), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t z;
    reset = 1'b1;
    ready = 1'b0;
    z = '{0, 0, 0, 0, 0, 0};
    drive_comb(z);
    model_clear();
    #2;
    assert_reset();
    chk_en = 1;
    release_reset();

    // comb120 = -50 wins: energies 80,80,400,80,80,80
    send_window('{10, 10, -50, 10, 10, 10});
    wait_valid(2, 120, 400, 1);

    // tie between 90 and 210 goes to the lower index
    send_window('{0, 100, 0, 0, 100, 0});
    wait_valid(1, 90, 800, 1);

    // silence: not locked
    send_window(z);
    wait_valid(0, 60, 0, 0);

    // single -128 sample rectifies to 128
    send_sample('{-128, 0, 0, 0, 0, 0}, 13);
    for (int i = 1; i < WIN; i++) send_sample(z, 13);
    wait_valid(0, 60, 128, 1);

    // reset mid-window with a strobe still in the delay line
    send_sample('{50, 0, 0, 0, 0, 0}, 13);
    send_sample('{50, 0, 0, 0, 0, 0}, 5);
    assert_reset();
    check_cleared("rst_mid");
    release_reset();

    // back-to-back random windows, strobes continuing through the scan
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < WIN; i++) begin
        rand_vec(v);
        send_sample(v, int'($urandom_range(13, 17)));
      end
    end
    repeat (8) @(posedge clk);
    #1;

    // reset on the third scan cycle: 8th strobe at R, scan R+13..R+17
    for (int i = 0; i < WIN - 1; i++) send_sample('{0, 0, 0, 90, 0, 0}, 13);
    send_sample('{0, 0, 0, 90, 0, 0}, 15);
    assert_reset();
    check_cleared("rst_scan");
    release_reset();

    // recovery window
    for (int i = 0; i < WIN; i++) begin
      rand_vec(v);
      send_sample(v, 13);
    end
    repeat (25) @(posedge clk);
    #1;
    chk("pending_results", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
